padding_window_buf: RTL and testbench

//  Parametrised zero-padding line buffer with a rolling window for the conv front end.

---
 rtl/padding_window_buf.sv | 162 ++++++++++++++++
 tb/tb_padding_window_buf.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/padding_window_buf.sv
// rtl/padding_window_buf.sv - zero-padded line assembler with a K-row rolling window for the conv front end
// Rows are assembled beat by beat, shifted into a K-row window, and frames are closed with PAD zero rows.
module padding_window_buf #(
    parameter int PIX_W = 8,
    parameter int CH    = 3,
    parameter int IMG_W = 416,
    parameter int IMG_H = 416,
    parameter int CHUNK = 8,
    parameter int PAD   = 1,
    localparam int K     = 2 * PAD + 1,
    localparam int ROW_W = (IMG_W + 2 * PAD) * PIX_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH*CHUNK*PIX_W-1:0]    in_data,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [CH*K*ROW_W-1:0]        win_data,
    output logic [$clog2(IMG_H)-1:0]     win_row,
    output logic                         win_last
);

    localparam int NB     = IMG_W / CHUNK;
    localparam int BW     = (NB > 1) ? $clog2(NB) : 1;
    localparam int SW     = $clog2(IMG_H + PAD + 1);
    localparam int RW     = $clog2(IMG_H);
    localparam int BEAT_W = CHUNK * PIX_W;
    localparam int LINE_W = IMG_W * PIX_W;

    generate
        if (IMG_H <= PAD || (IMG_W % CHUNK) != 0) begin : g_param_check
            $error("padding_window_buf: requires IMG_H > PAD and IMG_W a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t state, state_next;

    // Only the interior pixels are stored; pad columns are tied to zero on the output.
    logic [CH-1:0][NB-1:0][BEAT_W-1:0] asm_row;
    logic [CH-1:0][K-1:0][LINE_W-1:0]  win_rows;
    logic [BW-1:0]                     beat_cnt;
    logic                              row_full;
    logic [SW-1:0]                     shifts;

    logic          accept;
    logic          flush_pend;
    logic          shift;
    logic          produce;
    logic          done;
    logic [SW-1:0] centre;

    always_comb begin
        in_ready   = en && (state != S_FLUSH) && !row_full;
        accept     = in_valid && in_ready;
        flush_pend = (state == S_FLUSH) && (shifts < SW'(IMG_H + PAD));
        shift      = en && (row_full || flush_pend) && (!win_valid || win_ready);
        produce    = shift && (shifts >= SW'(PAD));
        centre     = shifts - SW'(PAD);
        done       = (state == S_FLUSH) && win_valid && win_ready && win_last;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FILL: begin
                if (shift && shifts == SW'(IMG_H - 1))
                    state_next = S_FLUSH;
                else if (produce)
                    state_next = S_RUN;
            end
            S_RUN: begin
                if (shift && shifts == SW'(IMG_H - 1))
                    state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (done)
                    state_next = S_FILL;
            end
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FILL;
        else if (!en)
            state <= S_FILL;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_row   <= '0;
            win_rows  <= '0;
            beat_cnt  <= '0;
            row_full  <= 1'b0;
            shifts    <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_last  <= 1'b0;
        end else if (!en || done) begin
            asm_row   <= '0;
            win_rows  <= '0;
            beat_cnt  <= '0;
            row_full  <= 1'b0;
            shifts    <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_last  <= 1'b0;
        end else begin
            if (accept) begin
                for (int c = 0; c < CH; c++)
                    asm_row[c][beat_cnt] <= in_data[c*BEAT_W +: BEAT_W];
                if (beat_cnt == BW'(NB - 1)) begin
                    beat_cnt <= '0;
                    row_full <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end

            // Flush shifts feed zero rows to close the bottom border of the frame.
            if (shift) begin
                for (int c = 0; c < CH; c++) begin
                    for (int k = 0; k < K - 1; k++)
                        win_rows[c][k] <= win_rows[c][k+1];
                    win_rows[c][K-1] <= (state == S_FLUSH) ? '0 : asm_row[c];
                end
                row_full <= 1'b0;
                shifts   <= shifts + 1'b1;
            end

            if (produce) begin
                win_valid <= 1'b1;
                win_row   <= RW'(centre);
                win_last  <= (centre == SW'(IMG_H - 1));
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            for (genvar k = 0; k < K; k++) begin : g_row
                assign win_data[(c*K+k)*ROW_W +: ROW_W] =
                    {{(PAD*PIX_W){1'b0}}, win_rows[c][k], {(PAD*PIX_W){1'b0}}};
            end
        end
    endgenerate

endmodule

// File: tb/tb_padding_window_buf.sv
// tb/tb_padding_window_buf.sv - self-checking bench for padding_window_buf (PAD=1 and PAD=2 instances)
module tb_padding_window_buf;

    localparam int PW   = 8;
    localparam int CHN  = 3;
    localparam int W    = 16;
    localparam int CK   = 8;
    localparam int NBT  = W / CK;
    localparam int HA   = 4;
    localparam int PA   = 1;
    localparam int KA   = 2 * PA + 1;
    localparam int DWA  = CHN * KA * (W + 2 * PA) * PW;
    localparam int HB   = 5;
    localparam int PB   = 2;
    localparam int KB   = 2 * PB + 1;
    localparam int DWB  = CHN * KB * (W + 2 * PB) * PW;
    localparam int MAXW = 2400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                    en_a, in_valid_a, in_ready_a, win_valid_a, win_ready_a, win_last_a;
    logic [CHN*CK*PW-1:0]    in_data_a;
    logic [DWA-1:0]          win_data_a;
    logic [1:0]              win_row_a;
    logic                    en_b, in_valid_b, in_ready_b, win_valid_b, win_ready_b, win_last_b;
    logic [CHN*CK*PW-1:0]    in_data_b;
    logic [DWB-1:0]          win_data_b;
    logic [2:0]              win_row_b;

    padding_window_buf #(.PIX_W(PW), .CH(CHN), .IMG_W(W), .IMG_H(HA), .CHUNK(CK), .PAD(PA)) dut_a (
        .clk(clk), .reset(reset), .en(en_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .win_valid(win_valid_a), .win_ready(win_ready_a), .win_data(win_data_a),
        .win_row(win_row_a), .win_last(win_last_a)
    );

    padding_window_buf #(.PIX_W(PW), .CH(CHN), .IMG_W(W), .IMG_H(HB), .CHUNK(CK), .PAD(PB)) dut_b (
        .clk(clk), .reset(reset), .en(en_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .win_valid(win_valid_b), .win_ready(win_ready_b), .win_data(win_data_b),
        .win_row(win_row_b), .win_last(win_last_b)
    );

    typedef struct {
        logic [MAXW-1:0] d;
        int              row;
        bit              last;
    } exp_t;

    exp_t       exp_a[$];
    exp_t       exp_b[$];
    exp_t       ea, eb;
    logic [7:0] img[CHN][8][W];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_win_a  = 0;
    int n_win_b  = 0;
    int cyc      = 0;
    int last_edge_a = -100;
    int cur_beat_a  = 0;
    int cur_beat_b  = 0;
    bit lat_en   = 1'b0;
    bit tx_done  = 1'b0;

    bit              hold_a = 1'b0;
    bit              prev_valid_a = 1'b0;
    logic [DWA-1:0]  prev_data_a;
    logic [1:0]      prev_row_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_win(input string tag, input logic [MAXW-1:0] obs, input logic [MAXW-1:0] expv);
        int bad;
        bad = -1;
        for (int i = MAXW / 8 - 1; i >= 0; i--)
            if (obs[i*8 +: 8] !== expv[i*8 +: 8]) bad = i;
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: byte %0d got %0h, expected %0h", tag, bad,
                   obs[bad*8 +: 8], expv[bad*8 +: 8]);
        end
    endtask

    // Reference window: row k holds input row r-pad+k, zero outside the frame and in pad columns.
    function automatic logic [MAXW-1:0] exp_win(input int pad, input int h, input int r);
        logic [MAXW-1:0] v;
        int k, rw, src;
        v  = '0;
        k  = 2 * pad + 1;
        rw = (W + 2 * pad) * PW;
        for (int c = 0; c < CHN; c++)
            for (int kk = 0; kk < k; kk++) begin
                src = r - pad + kk;
                if (src >= 0 && src < h)
                    for (int x = 0; x < W; x++)
                        v[(c*k+kk)*rw + (x+pad)*PW +: PW] = img[c][src][x];
            end
        return v;
    endfunction

    task automatic gen_frame(input bit sel, input bit push);
        exp_t e;
        int   h, pad;
        h   = sel ? HB : HA;
        pad = sel ? PB : PA;
        for (int c = 0; c < CHN; c++)
            for (int r = 0; r < 8; r++)
                for (int x = 0; x < W; x++)
                    img[c][r][x] = 8'($urandom);
        if (push)
            for (int r = 0; r < h; r++) begin
                e.d    = exp_win(pad, h, r);
                e.row  = r;
                e.last = (r == h - 1);
                if (sel) exp_b.push_back(e);
                else     exp_a.push_back(e);
            end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input bit sel, input int r, input int b);
        logic [CHN*CK*PW-1:0] d;
        bit acc;
        int n;
        for (int c = 0; c < CHN; c++)
            for (int p = 0; p < CK; p++)
                d[c*CK*PW + p*PW +: PW] = img[c][r][b*CK+p];
        if (sel) begin in_data_b = d; cur_beat_b = b; in_valid_b = 1'b1; end
        else     begin in_data_a = d; cur_beat_a = b; in_valid_a = 1'b1; end
        n = 0;
        acc = 1'b0;
        while (!acc && n < 500) begin
            acc = sel ? in_ready_b : in_ready_a;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk(sel ? "b_send_timeout" : "a_send_timeout", acc, 1);
        if (sel) in_valid_b = 1'b0;
        else     in_valid_a = 1'b0;
    endtask

    task automatic send_row(input bit sel, input int r);
        for (int b = 0; b < NBT; b++)
            send_beat(sel, r, b);
    endtask

    task automatic send_frame(input bit sel);
        for (int r = 0; r < (sel ? HB : HA); r++)
            send_row(sel, r);
    endtask

    task automatic drain(input bit sel);
        int n;
        n = 0;
        while ((sel ? exp_b.size() : exp_a.size()) != 0 && n < 1000) begin
            step(1);
            n++;
        end
        chk(sel ? "b_drain" : "a_drain", sel ? exp_b.size() : exp_a.size(), 0);
    endtask

    task automatic abort_setup();
        gen_frame(1'b0, 1'b0);
        win_ready_a = 1'b0;
        send_row(1'b0, 0);
        send_row(1'b0, 1);
        send_beat(1'b0, 2, 0);
        chk("abort_window_held", win_valid_a, 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && en_a) begin
            if (hold_a) begin
                chk("a_hold_valid", win_valid_a, 1);
                chk_win("a_hold_data", MAXW'(win_data_a), MAXW'(prev_data_a));
                chk("a_hold_row", win_row_a, prev_row_a);
            end
            if (lat_en && win_valid_a && !prev_valid_a)
                chk("a_latency", cyc - last_edge_a, 1);
            if (in_valid_a && in_ready_a && cur_beat_a == NBT - 1)
                last_edge_a = cyc + 1;
            if (win_valid_a && win_ready_a) begin
                chk("a_window_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) begin
                    ea = exp_a.pop_front();
                    chk_win("a_data", MAXW'(win_data_a), ea.d);
                    chk("a_row", win_row_a, ea.row);
                    chk("a_last", win_last_a, ea.last);
                    n_win_a++;
                end
            end
        end
        if (!reset && en_b && win_valid_b && win_ready_b) begin
            chk("b_window_expected", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) begin
                eb = exp_b.pop_front();
                chk_win("b_data", MAXW'(win_data_b), eb.d);
                chk("b_row", win_row_b, eb.row);
                chk("b_last", win_last_b, eb.last);
                n_win_b++;
            end
        end
        hold_a       = !reset && en_a && win_valid_a && !win_ready_a;
        prev_valid_a = win_valid_a;
        prev_data_a  = win_data_a;
        prev_row_a   = win_row_a;
    end

    initial begin
        int base, n;
        reset = 1'b1; en_a = 1'b1; en_b = 1'b1;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_data_a = '0; in_data_b = '0;
        win_ready_a = 1'b1; win_ready_b = 1'b1;
        step(3);
        chk("rst_a_valid", win_valid_a, 0);
        chk_win("rst_a_data", MAXW'(win_data_a), '0);
        chk("rst_a_row", win_row_a, 0);
        chk("rst_a_last", win_last_a, 0);
        chk("rst_b_valid", win_valid_b, 0);
        reset = 1'b0;
        #1;
        chk("rst_a_in_ready", in_ready_a, 1);
        chk("rst_b_in_ready", in_ready_b, 1);
        step(1);

        // one PAD=1 frame, consumer always ready
        base = n_win_a;
        gen_frame(1'b0, 1'b1);
        send_frame(1'b0);
        drain(1'b0);
        chk("a_frame1_windows", n_win_a - base, HA);

        // consumer stalls 20 cycles after the first window
        base = n_win_a;
        gen_frame(1'b0, 1'b1);
        win_ready_a = 1'b0;
        tx_done = 1'b0;
        fork
            begin
                send_frame(1'b0);
                tx_done = 1'b1;
            end
        join_none
        n = 0;
        while (!win_valid_a && n < 200) begin step(1); n++; end
        chk("a_bp_first_valid", win_valid_a, 1);
        step(20);
        chk("a_bp_in_ready", in_ready_a, 0);
        chk("a_bp_row_held", win_row_a, 0);
        chk("a_bp_tx_pending", tx_done, 0);
        win_ready_a = 1'b1;
        n = 0;
        while (!tx_done && n < 1000) begin step(1); n++; end
        chk("a_bp_tx_done", tx_done, 1);
        drain(1'b0);
        chk("a_bp_windows", n_win_a - base, HA);

        // two back-to-back frames with latency tracking
        base = n_win_a;
        lat_en = 1'b1;
        gen_frame(1'b0, 1'b1);
        send_frame(1'b0);
        gen_frame(1'b0, 1'b1);
        send_frame(1'b0);
        drain(1'b0);
        lat_en = 1'b0;
        chk("a_b2b_windows", n_win_a - base, 2 * HA);

        // PAD=2 instance
        base = n_win_b;
        gen_frame(1'b1, 1'b1);
        send_row(1'b1, 0);
        send_row(1'b1, 1);
        step(3);
        chk("b_no_early_window", win_valid_b, 0);
        send_row(1'b1, 2);
        step(1);
        chk("b_first_window", win_valid_b, 1);
        send_row(1'b1, 3);
        send_row(1'b1, 4);
        drain(1'b1);
        chk("b_windows", n_win_b - base, HB);

        // async reset mid-row
        abort_setup();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_valid", win_valid_a, 0);
        chk_win("areset_data", MAXW'(win_data_a), '0);
        chk("areset_row", win_row_a, 0);
        chk("areset_last", win_last_a, 0);
        step(2);
        reset = 1'b0;
        win_ready_a = 1'b1;
        #1;
        chk("areset_in_ready", in_ready_a, 1);
        base = n_win_a;
        gen_frame(1'b0, 1'b1);
        send_frame(1'b0);
        drain(1'b0);
        chk("areset_windows", n_win_a - base, HA);

        // synchronous clear via en
        abort_setup();
        en_a = 1'b0;
        #1;
        chk("en_before_edge_valid", win_valid_a, 1);
        step(1);
        chk("en_clear_valid", win_valid_a, 0);
        chk_win("en_clear_data", MAXW'(win_data_a), '0);
        chk("en_clear_row", win_row_a, 0);
        en_a = 1'b1;
        win_ready_a = 1'b1;
        #1;
        chk("en_in_ready", in_ready_a, 1);
        base = n_win_a;
        gen_frame(1'b0, 1'b1);
        send_frame(1'b0);
        drain(1'b0);
        chk("en_windows", n_win_a - base, HA);

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
